// File: rtl/cpu_sel_pkg.sv
// cpu_sel_pkg
// Shared definitions for the register/operation select path. The select
// decoder and the one-hot to binary encoder both pull their widths, the
// select vector and code types, and the "nothing selected" code from here,
// so the two ends of the select bus cannot drift apart.
//
// Contents:
//   OH_W, BIN_W, CNT_W  default widths (one-hot vector, code, error counter)
//   sel_onehot_t        one-hot select vector
//   sel_code_t          binary select code (0 = nothing selected)
//   CODE_NONE           code for an all-zero select vector
//   occ_state_t         occupancy of the encoder's 2-entry output buffer
package cpu_sel_pkg;

    localparam int OH_W  = 20;
    localparam int BIN_W = 5;
    localparam int CNT_W = 8;

    typedef logic [OH_W-1:0]  sel_onehot_t;
    typedef logic [BIN_W-1:0] sel_code_t;

    // Code 0 is reserved for "no bit set"; bit k maps to code k+1.
    localparam sel_code_t CODE_NONE = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/onehot_prio_enc.sv
// onehot_prio_enc
// Purely combinational lowest-index priority encoder with multi-hot detect.
// An all-zero vector gives code 0; otherwise the lowest set bit k gives
// code k+1. err flags a vector with two or more bits set.
//
// Ports:
//   onehot  in   OH_W   select vector to encode
//   code    out  BIN_W  encoded value
//   err     out  1      more than one bit set
module onehot_prio_enc #(
    parameter int OH_W  = cpu_sel_pkg::OH_W,
    parameter int BIN_W = cpu_sel_pkg::BIN_W
) (
    input  logic [OH_W-1:0]  onehot,
    output logic [BIN_W-1:0] code,
    output logic             err
);
    import cpu_sel_pkg::*;

    // Scanning from the top down lets the lowest set bit win the last write.
    // v & (v - 1) clears the lowest set bit, so anything left means multi-hot.
    always_comb begin
        code = BIN_W'(CODE_NONE);
        for (int k = OH_W - 1; k >= 0; k--) begin
            if (onehot[k]) begin
                code = BIN_W'(k + 1);
            end
        end
        err = |(onehot & (onehot - OH_W'(1)));
    end

endmodule

// File: rtl/onehot_to_binary_enc.sv
// onehot_to_binary_enc
// Compresses the control unit's one-hot select vector into its binary code
// for the trace/debug and writeback-index paths. Words are encoded at the
// input transfer and held in a 2-entry FIFO so that backpressure on the
// output never drops a word. Multi-hot vectors are encoded to their lowest
// set bit and flagged with out_err.
//
// Optional build macro: ONEHOT_ENC_ERRCNT_EN adds err_count, a saturating
// count of accepted multi-hot words (cleared only by reset).
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      in_onehot is presented
//   in_ready   out  1      a word can be accepted this cycle
//   in_onehot  in   OH_W   one-hot select vector
//   out_valid  out  1      out_code/out_err hold a result
//   out_ready  in   1      consumer takes the result this cycle
//   out_code   out  BIN_W  encoded value of the head word
//   out_err    out  1      head word was multi-hot
//   err_count  out  CNT_W  saturating multi-hot count (macro only)
module onehot_to_binary_enc #(
    parameter int OH_W  = cpu_sel_pkg::OH_W,
    parameter int BIN_W = cpu_sel_pkg::BIN_W
`ifdef ONEHOT_ENC_ERRCNT_EN
    ,
    parameter int CNT_W = cpu_sel_pkg::CNT_W
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OH_W-1:0]  in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] out_code,
    output logic             out_err
`ifdef ONEHOT_ENC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);
    import cpu_sel_pkg::*;

    occ_state_t       state_q, state_d;
    logic [BIN_W-1:0] head_code_q, head_code_d;
    logic             head_err_q, head_err_d;
    logic [BIN_W-1:0] tail_code_q, tail_code_d;
    logic             tail_err_q, tail_err_d;

    logic [BIN_W-1:0] enc_code;
    logic             enc_err;
    logic             in_fire;
    logic             out_fire;

    onehot_prio_enc #(
        .OH_W  (OH_W),
        .BIN_W (BIN_W)
    ) u_prio_enc (
        .onehot (in_onehot),
        .code   (enc_code),
        .err    (enc_err)
    );

    // Handshake flags come straight from the occupancy register, so there is
    // no combinational path from out_ready back to in_ready.
    assign in_ready  = (state_q != OCC_TWO);
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_code  = head_code_q;
    assign out_err   = head_err_q;

    // in_valid gates every use of the encoder result, so an undriven
    // in_onehot while idle never reaches the buffer.
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Buffer control: the head entry always drives the outputs. A pop from
    // TWO shifts the tail into the head; a push while ONE lands in the tail
    // unless the head leaves in the same cycle, in which case it replaces the
    // head directly. Vacated entries are cleared to keep the outputs quiet.
    always_comb begin
        state_d     = state_q;
        head_code_d = head_code_q;
        head_err_d  = head_err_q;
        tail_code_d = tail_code_q;
        tail_err_d  = tail_err_q;
        case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    head_code_d = enc_code;
                    head_err_d  = enc_err;
                    state_d     = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    head_code_d = enc_code;
                    head_err_d  = enc_err;
                end else if (in_fire) begin
                    tail_code_d = enc_code;
                    tail_err_d  = enc_err;
                    state_d     = OCC_TWO;
                end else if (out_fire) begin
                    head_code_d = BIN_W'(CODE_NONE);
                    head_err_d  = 1'b0;
                    state_d     = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (out_fire) begin
                    head_code_d = tail_code_q;
                    head_err_d  = tail_err_q;
                    tail_code_d = BIN_W'(CODE_NONE);
                    tail_err_d  = 1'b0;
                    state_d     = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
    end

    // Buffer and occupancy registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= OCC_EMPTY;
            head_code_q <= BIN_W'(CODE_NONE);
            head_err_q  <= 1'b0;
            tail_code_q <= BIN_W'(CODE_NONE);
            tail_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_code_q <= head_code_d;
            head_err_q  <= head_err_d;
            tail_code_q <= tail_code_d;
            tail_err_q  <= tail_err_d;
        end
    end

`ifdef ONEHOT_ENC_ERRCNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Counted at acceptance, not at output, and held at all-ones once full.
    always_comb begin
        err_count_d = err_count_q;
        if (in_fire && enc_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_onehot_to_binary_enc.sv
// tb_onehot_to_binary_enc
// Self-checking bench for onehot_to_binary_enc. A queue of expected
// {code, err} words stands in for the output buffer; expected codes come from
// isolating the lowest set bit arithmetically. Inputs change just after the
// rising edge and outputs are compared on the falling edge.
// Build with ONEHOT_ENC_ERRCNT_EN to also track err_count.
module tb_onehot_to_binary_enc;
    import cpu_sel_pkg::*;

    localparam int ERR_MAX = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_onehot = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_code;
    logic        out_err;
`ifdef ONEHOT_ENC_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    typedef struct {
        int code;
        bit err;
    } exp_t;

    exp_t model_q[$];
    int   exp_errs = 0;
    int   checks = 0;
    int   errors = 0;

    onehot_to_binary_enc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_onehot (in_onehot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err)
`ifdef ONEHOT_ENC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected result from the encoding rule: v & -v isolates the lowest set
    // bit, whose log2 is its index k; the code is k+1.
    function automatic exp_t refEncode(input logic [19:0] v);
        exp_t        e;
        logic [19:0] low;
        if (v == 20'd0) begin
            e.code = 0;
            e.err  = 1'b0;
        end else begin
            low    = v & (~v + 20'd1);
            e.code = $clog2(low) + 1;
            e.err  = ($countones(v) > 1);
        end
        return e;
    endfunction

    function automatic logic [19:0] twoBits();
        int a;
        int b;
        a = $urandom_range(0, 19);
        b = (a + 1 + $urandom_range(0, 18)) % 20;
        return (20'd1 << a) | (20'd1 << b);
    endfunction

    // One clock cycle: drive, check on the falling edge, then advance the
    // model with whatever transfers the handshake allows on the next edge.
    task automatic applyStimulus(input bit iv, input logic [19:0] vec, input bit ordy);
        bit   push;
        bit   pop;
        exp_t e;
        in_valid  = iv;
        in_onehot = vec;
        out_ready = ordy;
        @(negedge clk);
        checkOutput("in_ready", {31'd0, in_ready}, (model_q.size() < 2) ? 32'd1 : 32'd0);
        checkOutput("out_valid", {31'd0, out_valid}, (model_q.size() != 0) ? 32'd1 : 32'd0);
        if (model_q.size() != 0) begin
            checkOutput("out_code", {27'd0, out_code}, model_q[0].code);
            checkOutput("out_err", {31'd0, out_err}, {31'd0, model_q[0].err});
        end
`ifdef ONEHOT_ENC_ERRCNT_EN
        checkOutput("err_count", {24'd0, err_count}, exp_errs);
`endif
        push = iv && (model_q.size() < 2);
        pop  = ordy && (model_q.size() != 0);
        if (pop) begin
            void'(model_q.pop_front());
        end
        if (push) begin
            e = refEncode(vec);
            model_q.push_back(e);
            if (e.err && exp_errs < ERR_MAX) begin
                exp_errs++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_out_code"}, {27'd0, out_code}, 32'd0);
        checkOutput({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
`ifdef ONEHOT_ENC_ERRCNT_EN
        checkOutput({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
`endif
    endtask

    // Reset is raised a few time units after a rising edge, well clear of
    // any clock edge, and released on a falling edge.
    task automatic asyncReset();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkResetState("async_rst");
        model_q.delete();
        exp_errs = 0;
        @(posedge clk);
        #1;
        checkResetState("rst_held");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] vec;
        int          kind;

        $display("[TB] onehot_to_binary_enc bench start");
        #12;
        checkResetState("por");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Sweep: zero, then every single bit, streaming with out_ready high.
        // Idle cycles drive X on in_onehot to show it is ignored.
        applyStimulus(1'b1, 20'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 20'd1 << i, 1'b1);
        end
        repeat (3) applyStimulus(1'b0, 'x, 1'b1);

        // Multi-hot words encode to their lowest bit with out_err set.
        applyStimulus(1'b1, 20'h00006, 1'b1);
        applyStimulus(1'b1, 20'h80001, 1'b1);
        repeat (2) applyStimulus(1'b0, 'x, 1'b1);

        // Backpressure: fill to two entries, hold off the third, release.
        applyStimulus(1'b1, 20'h00010, 1'b0);
        applyStimulus(1'b1, 20'h00020, 1'b0);
        applyStimulus(1'b1, 20'h00040, 1'b0);
        applyStimulus(1'b1, 20'h00040, 1'b0);
        applyStimulus(1'b1, 20'h00040, 1'b1);
        applyStimulus(1'b0, 'x, 1'b1);
        repeat (2) applyStimulus(1'b0, 'x, 1'b1);

        // Simultaneous push and pop while holding one entry.
        applyStimulus(1'b1, 20'h00001, 1'b0);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b1, 20'd1 << i, 1'b1);
        end
        repeat (2) applyStimulus(1'b0, 'x, 1'b1);

        // Reset while full, then a lone word afterwards.
        applyStimulus(1'b1, 20'h00010, 1'b0);
        applyStimulus(1'b1, 20'h00020, 1'b0);
        asyncReset();
        applyStimulus(1'b1, 20'h00008, 1'b0);
        applyStimulus(1'b0, 'x, 1'b1);
        applyStimulus(1'b0, 'x, 1'b1);

        // Random traffic mixing zero, single-bit and multi-hot words.
        repeat (400) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                vec = 20'd0;
            end else if (kind < 6) begin
                vec = 20'd1 << $urandom_range(0, 19);
            end else if (kind < 8) begin
                vec = twoBits();
            end else begin
                vec = 20'($urandom);
            end
            applyStimulus(($urandom_range(0, 3) != 0), vec, ($urandom_range(0, 2) != 0));
        end
        repeat (3) applyStimulus(1'b0, 'x, 1'b1);

        // Enough multi-hot words to push the error count past saturation.
        repeat (300) applyStimulus(1'b1, twoBits(), 1'b1);
        repeat (3) applyStimulus(1'b0, 'x, 1'b1);
`ifdef ONEHOT_ENC_ERRCNT_EN
        checkOutput("err_sat", {24'd0, err_count}, ERR_MAX);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_to_binary_enc.md
Name: onehot_to_binary_enc

Overview:
- Inverse of the register/operation select decoder: compresses a 20-bit one-hot select vector back to its 5-bit binary code.
- Sits between the control unit's one-hot select bus and the trace/debug and writeback-index paths.
- Registered, with a valid/ready handshake and a 2-entry output buffer so backpressure never drops a word.
- Flags illegal vectors: zero-hot is legal (code 0); multi-hot is illegal.

Parameters:
- OH_W, 20, one-hot input width; legal range 2..31.
- BIN_W, 5, binary output width; must satisfy 2^BIN_W > OH_W.
- CNT_W, 8, error-counter width (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_onehot is presented.
- in_ready  output  1  block can accept a word this cycle.
- in_onehot  input  OH_W  one-hot select vector.
- out_valid  output  1  out_code/out_err hold a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_code  output  BIN_W  encoded value.
- out_err  output  1  multi-hot input detected for this word.
- err_count  output  CNT_W  saturating count of multi-hot words (optional feature only).

Behaviour:
- Encoding rule:
  - All-zero input gives code 0, out_err=0.
  - Exactly bit k set gives code k+1, out_err=0.
  - Two or more bits set gives the lowest set index k, code k+1, out_err=1.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Storage is a 2-entry FIFO (skid buffer) holding {code, err}. The encode is combinational on in_onehot and written at the input transfer.
- Occupancy states and transitions:
  - EMPTY -> ONE on input transfer.
  - ONE -> TWO on input transfer without output transfer.
  - ONE -> EMPTY on output transfer without input transfer.
  - ONE stays ONE on a simultaneous input and output transfer.
  - TWO -> ONE on output transfer. No input is accepted in TWO.
- in_ready = (state != TWO). It is registered-state derived only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_code/out_err always show the head entry and stay stable while out_valid && !out_ready.
- Latency: a word accepted in cycle N is visible on out_code in cycle N+1 if the buffer was empty.
- Ordering is strictly FIFO. Throughput is 1 word per cycle with out_ready held high.
- Reset (asynchronous, any time, including mid-transfer):
  - state=EMPTY, both entries cleared.
  - out_valid=0, out_code=0, out_err=0, in_ready=1 during and after reset, err_count=0.
  - Words in flight are discarded.
- in_onehot is ignored when in_valid=0. X on in_onehot with in_valid=0 must not propagate to outputs.

Optional Feature:
- Macro: ONEHOT_ENC_ERRCNT_EN.
- Defined:
  - err_count port exists.
  - Increments by 1 on each input transfer whose word has err=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package cpu_sel_pkg: OH_W/BIN_W constants, the sel_onehot_t and sel_code_t typedefs, and the CODE_NONE=0 constant. The existing decoder uses the same package.
- One natural sub-module, onehot_prio_enc: purely combinational lowest-index priority encode plus multi-hot detect, producing {code, err}. The top module holds the FIFO and handshake.

Test Plan:
- Sweep: send 0x00000, then each single bit 0x00001..0x80000 with out_ready=1 -> codes 0,1..20 in order, one per cycle after 1-cycle latency, out_err=0 throughout.
- Multi-hot: send 0x00006, then 0x80001 -> codes 2 then 1, out_err=1 both. With ONEHOT_ENC_ERRCNT_EN, err_count=2.
- Backpressure:
  - Hold out_ready=0 and push 0x00010, 0x00020, 0x00040 -> first two accepted.
  - in_ready=0 at TWO, third held off.
  - Release out_ready -> outputs 5,6,7 in order, nothing lost or duplicated.
- Simultaneous: at ONE, assert an input and an output transfer together for 10 cycles with inputs 0x00001..0x00200 -> state stays ONE and codes 1..10 emerge in order.
- Reset mid-operation: fill to TWO, assert reset asynchronously between clock edges -> out_valid=0, out_code=0, in_ready=1 immediately. The first post-reset word (0x00008, code 4) appears alone.
- Saturation (ONEHOT_ENC_ERRCNT_EN, CNT_W=8): send 300 multi-hot words -> err_count reaches 255 and holds.
